agendador_medida_dht11: RTL and testbench
=========================================

// Module: agendador_medida_dht11
// PURPOSE
//  Measurement scheduler for the TUSCA temperature path. It triggers the DHT11 interface periodically
//  and enforces the sensor's minimum spacing between reads. It applies a per-read timeout and
//  validates the 40-bit frame checksum. It latches humidity/temperature for the level classifier
//  and the serial transmitter, and holds off new reads while the config manager is receiving.
// PARAMETERS
//  PERIODO_MEDIDA  100_000_000  clock cycles between consecutive dht_medir pulses (2 s @ 50 MHz)
//  TIMEOUT         5_000_000    max cycles from dht_medir to dht_pronto before abort
//  MAX_TENTATIVAS  3            consecutive failed reads that raise erro_medida (>=1)
// PORTS
//  clock         in   1   system clock, 50 MHz
//  reset         in   1   asynchronous, active-low reset
//  start         in   1   pulse; leaves OCIOSO and issues first read immediately
//  parar         in   1   pulse; returns to OCIOSO from any state
//  pausa         in   1   level from config manager; blocks new reads while high
//  dht_pronto    in   1   pulse from DHT11 interface: frame received
//  dht_erro      in   1   pulse from DHT11 interface: protocol error
//  dht_dados     in   40  frame {umid_int, umid_dec, temp_int, temp_dec, checksum}, valid with dht_pronto
//  dht_medir     out  1   one-cycle pulse starting a DHT11 read
//  dht_abort     out  1   one-cycle pulse forcing the DHT11 interface back to idle
//  umidade       out  8   latched dht_dados[39:32]
//  temperatura   out  8   latched dht_dados[23:16] (filtered if macro enabled)
//  medida_valida out  1   high once any valid frame has been latched
//  nova_medida   out  1   one-cycle pulse when umidade/temperatura update
//  erro_medida   out  1   high after MAX_TENTATIVAS consecutive failures
//  falhas        out  2   consecutive failure count, saturating
//  db_estado     out  4   current FSM state
// BEHAVIOUR
//  - Reset (reset==0, async): state OCIOSO. All outputs 0. Period/timeout counters 0.
//  - OCIOSO: start -> DISPARA. Any other input ignored.
//  - DISPARA (1 cyc): dht_medir=1. Period counter cleared here. Timeout counter cleared. -> AGUARDA.
//  - AGUARDA: dht_erro -> FALHA (dht_erro wins over dht_pronto in the same cycle). dht_pronto -> VERIFICA,
//    registering dht_dados on the same edge. Timeout cnt==TIMEOUT-1 without pronto -> FALHA with
//    dht_abort=1 for 1 cyc. pronto on the timeout cycle wins.
//  - VERIFICA (1 cyc): ok = (d[39:32]+d[31:24]+d[23:16]+d[15:8]) mod 256 == d[7:0]. ok -> ATUALIZA, else FALHA.
//  - ATUALIZA (1 cyc): latch outputs, nova_medida=1, medida_valida=1, falhas=0, erro_medida=0 -> ESPERA.
//  - FALHA (1 cyc): outputs unchanged. falhas+1 saturates at 3. If the new count >= MAX_TENTATIVAS,
//    erro_medida=1. -> ESPERA.
//  - ESPERA: period counter runs. pausa=1 -> PAUSADO (counter frozen). cnt==PERIODO_MEDIDA-1 -> DISPARA,
//    so successive dht_medir pulses are exactly PERIODO_MEDIDA cycles apart. A failure retries on the
//    same schedule.
//  - PAUSADO: counter frozen. pausa=0 -> ESPERA, resuming the count. pausa in AGUARDA/VERIFICA does not
//    abort the in-flight read; it takes effect on entry to ESPERA.
//  - parar in any non-OCIOSO state -> OCIOSO next cycle. If in AGUARDA, also dht_abort=1 that cycle.
//    Latched data, medida_valida and erro_medida are kept. A late dht_pronto in OCIOSO is ignored.
//  - start while not in OCIOSO is ignored. parar and start in the same cycle: parar wins.
//  - Counters are sized $clog2 of their parameter. No wrap beyond terminal values.
// CONFIGURATION
//  Macro TUSCA_MEDIA_TEMPERATURA_EN:
//   - Defined: temperatura = floor(sum of last 4 valid temp_int / 4), using a 4-entry buffer and a
//     10-bit sum. The first valid sample prefills all 4 entries. The buffer is cleared only by reset.
//   - Undefined: temperatura = raw temp_int of the last valid frame. umidade is always raw.
// STRUCTURE
//  - tusca_medida_pkg: FSM state encodings (OCIOSO=0, DISPARA=1, AGUARDA=2, VERIFICA=3, ATUALIZA=4,
//    FALHA=5, ESPERA=6, PAUSADO=7), DHT11 frame field offsets, checksum function.
//  - Sub-module filtro_media_temperatura (4-tap moving average), instantiated only under the macro.
// TESTING  (PERIODO_MEDIDA=1000, TIMEOUT=200, MAX_TENTATIVAS=3)
//  1. reset, start; model returns 40'h123422026a -> nova_medida 1 cyc, umidade=8'h12,
//     temperatura=8'h22, medida_valida=1; next dht_medir exactly 1000 cyc after first.
//  2. next frame 40'h2345aab2ab (bad checksum) -> no nova_medida, outputs stay 12/22, falhas=1;
//     following 40'h2345aab2c4 -> umidade=8'h23, temperatura=8'haa, falhas=0.
//  3. no response on 3 reads -> dht_abort 200 cyc after each dht_medir, erro_medida=1 after third;
//     next good frame clears erro_medida.
//  4. pausa high at ESPERA count 400 for 5000 cyc -> no dht_medir while paused; next dht_medir 600 cyc
//     after pausa falls.
//  5. parar in AGUARDA -> dht_abort same cycle, db_estado=0, late dht_pronto ignored. reset low
//     mid-read -> all outputs 0 asynchronously.
//  6. macro on, valid temps 20,22,24,26 -> temperatura 20,20,21,23 (decimal).

Source files
------------

// File: rtl/tusca_medida_pkg.sv
// Shared definitions for the TUSCA DHT11 measurement scheduler:
// FSM state encodings, DHT11 frame field offsets and the checksum test.
package tusca_medida_pkg;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        DISPARA  = 4'd1,
        AGUARDA  = 4'd2,
        VERIFICA = 4'd3,
        ATUALIZA = 4'd4,
        FALHA    = 4'd5,
        ESPERA   = 4'd6,
        PAUSADO  = 4'd7
    } estado_t;

    // Bit offsets of the 8-bit fields inside the 40-bit DHT11 frame.
    localparam int CAMPO_UMID_INT = 32;
    localparam int CAMPO_UMID_DEC = 24;
    localparam int CAMPO_TEMP_INT = 16;
    localparam int CAMPO_TEMP_DEC = 8;
    localparam int CAMPO_CHECKSUM = 0;

    function automatic logic [7:0] campo(input logic [39:0] quadro, input int offset);
        return quadro[offset +: 8];
    endfunction

    // The sensor's checksum is the low byte of the sum of the four data bytes.
    function automatic logic checksum_ok(input logic [39:0] quadro);
        logic [7:0] soma;
        soma = campo(quadro, CAMPO_UMID_INT) + campo(quadro, CAMPO_UMID_DEC)
             + campo(quadro, CAMPO_TEMP_INT) + campo(quadro, CAMPO_TEMP_DEC);
        return soma == campo(quadro, CAMPO_CHECKSUM);
    endfunction

endpackage

// File: rtl/filtro_media_temperatura.sv
// 4-tap moving average of the integer temperature byte. The first sample
// after reset fills the whole window so the output starts at that value.
// Used by agendador_medida_dht11 only when TUSCA_MEDIA_TEMPERATURA_EN is defined.
module filtro_media_temperatura (
    input  logic       clock,
    input  logic       reset,
    input  logic       carregar,
    input  logic [7:0] amostra,
    output logic [7:0] media
);

    logic [7:0] janela [4];
    logic       preenchido;
    logic [9:0] soma;

    // Window shift register: prefill on the first sample, shift afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the window is small and must restart empty after reset, so it is reset like any other register.
            for (int i = 0; i < 4; i++) janela[i] <= '0;
            preenchido <= 1'b0;
        end else if (carregar) begin
            // NOTE: non-blocking assignments let every tap read its neighbour's old value in the same edge.
            if (!preenchido) begin
                for (int i = 0; i < 4; i++) janela[i] <= amostra;
                preenchido <= 1'b1;
            end else begin
                janela[0] <= amostra;
                for (int i = 1; i < 4; i++) janela[i] <= janela[i-1];
            end
        end
    end

    assign soma  = 10'(janela[0]) + 10'(janela[1]) + 10'(janela[2]) + 10'(janela[3]);
    assign media = 8'(soma >> 2);

endmodule

// File: rtl/agendador_medida_dht11.sv
// Periodic DHT11 measurement scheduler: issues reads every PERIODO_MEDIDA
// cycles, aborts reads after TIMEOUT cycles, validates the frame checksum,
// counts consecutive failures and holds off reads while pausa is high.
// Optional build macro TUSCA_MEDIA_TEMPERATURA_EN: temperatura becomes the
// 4-sample moving average of temp_int instead of the raw value.
module agendador_medida_dht11
    import tusca_medida_pkg::*;
#(
    parameter int PERIODO_MEDIDA = 100_000_000,
    parameter int TIMEOUT        = 5_000_000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        parar,
    input  logic        pausa,
    input  logic        dht_pronto,
    input  logic        dht_erro,
    input  logic [39:0] dht_dados,
    output logic        dht_medir,
    output logic        dht_abort,
    output logic [7:0]  umidade,
    output logic [7:0]  temperatura,
    output logic        medida_valida,
    output logic        nova_medida,
    output logic        erro_medida,
    output logic [1:0]  falhas,
    output logic [3:0]  db_estado
);

    localparam int PW = (PERIODO_MEDIDA > 1) ? $clog2(PERIODO_MEDIDA) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PER_FIM = PW'(PERIODO_MEDIDA - 1);
    localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT - 1);

    estado_t       estado;
    logic [PW-1:0] cnt_periodo;
    logic [TW-1:0] cnt_timeout;
    logic [39:0]   quadro;
    logic [PW-1:0] periodo_inc;
    logic [TW-1:0] timeout_inc;
    logic [1:0]    falhas_nova;
    logic          erro_novo;
    logic [7:0]    temp_nova;

`ifdef TUSCA_MEDIA_TEMPERATURA_EN
    logic [7:0] temp_media;

    filtro_media_temperatura u_filtro (
        .clock    (clock),
        .reset    (reset),
        .carregar (estado == VERIFICA && checksum_ok(quadro)),
        .amostra  (campo(quadro, CAMPO_TEMP_INT)),
        .media    (temp_media)
    );

    assign temp_nova = temp_media;
`else
    assign temp_nova = campo(quadro, CAMPO_TEMP_INT);
`endif

    assign db_estado = estado;

    // Saturating counter increments and the next failure count.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        periodo_inc = (cnt_periodo >= PER_FIM) ? PER_FIM : cnt_periodo + PW'(1);
        timeout_inc = (cnt_timeout >= TMO_FIM) ? TMO_FIM : cnt_timeout + TW'(1);
        falhas_nova = (falhas == 2'd3) ? 2'd3 : falhas + 2'd1;
        erro_novo   = int'(falhas_nova) >= MAX_TENTATIVAS;
    end

    // Scheduler FSM with registered outputs; the period counter runs in
    // every active state except PAUSADO so reads stay on a fixed grid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= OCIOSO;
            cnt_periodo   <= '0;
            cnt_timeout   <= '0;
            quadro        <= '0;
            dht_medir     <= 1'b0;
            dht_abort     <= 1'b0;
            umidade       <= '0;
            temperatura   <= '0;
            medida_valida <= 1'b0;
            nova_medida   <= 1'b0;
            erro_medida   <= 1'b0;
            falhas        <= '0;
        end else begin
            dht_medir   <= 1'b0;
            dht_abort   <= 1'b0;
            nova_medida <= 1'b0;

            if (parar && estado != OCIOSO) begin
                estado      <= OCIOSO;
                dht_abort   <= (estado == AGUARDA);
                cnt_periodo <= '0;
                cnt_timeout <= '0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (start && !parar) begin
                            estado      <= DISPARA;
                            dht_medir   <= 1'b1;
                            cnt_periodo <= '0;
                            cnt_timeout <= '0;
                        end
                    end
                    DISPARA: begin
                        estado      <= AGUARDA;
                        cnt_periodo <= periodo_inc;
                        cnt_timeout <= timeout_inc;
                    end
                    AGUARDA: begin
                        cnt_periodo <= periodo_inc;
                        if (dht_erro) begin
                            estado <= FALHA;
                        end else if (dht_pronto) begin
                            estado <= VERIFICA;
                            quadro <= dht_dados;
                        end else if (cnt_timeout >= TMO_FIM) begin
                            estado    <= FALHA;
                            dht_abort <= 1'b1;
                        end else begin
                            cnt_timeout <= timeout_inc;
                        end
                    end
                    VERIFICA: begin
                        cnt_periodo <= periodo_inc;
                        estado      <= checksum_ok(quadro) ? ATUALIZA : FALHA;
                    end
                    ATUALIZA: begin
                        cnt_periodo   <= periodo_inc;
                        umidade       <= campo(quadro, CAMPO_UMID_INT);
                        temperatura   <= temp_nova;
                        nova_medida   <= 1'b1;
                        medida_valida <= 1'b1;
                        falhas        <= '0;
                        erro_medida   <= 1'b0;
                        estado        <= ESPERA;
                    end
                    FALHA: begin
                        cnt_periodo <= periodo_inc;
                        falhas      <= falhas_nova;
                        if (erro_novo) erro_medida <= 1'b1;
                        estado      <= ESPERA;
                    end
                    ESPERA: begin
                        if (pausa) begin
                            estado <= PAUSADO;
                        end else if (cnt_periodo >= PER_FIM) begin
                            estado      <= DISPARA;
                            dht_medir   <= 1'b1;
                            cnt_periodo <= '0;
                            cnt_timeout <= '0;
                        end else begin
                            cnt_periodo <= periodo_inc;
                        end
                    end
                    PAUSADO: begin
                        if (!pausa) begin
                            estado      <= ESPERA;
                            cnt_periodo <= periodo_inc;
                        end
                    end
                    default: estado <= OCIOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agendador_medida_dht11.sv
// Self-checking bench for agendador_medida_dht11 with PERIODO_MEDIDA=1000,
// TIMEOUT=200, MAX_TENTATIVAS=3. A table of reads drives a DHT11 model; good
// frames push expected values to a scoreboard popped on nova_medida.
// Build with TUSCA_MEDIA_TEMPERATURA_EN to expect averaged temperatures.
module tb_agendador_medida_dht11;

    localparam int PERIODO = 1000;
    localparam int TMO     = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        parar = 1'b0;
    logic        pausa = 1'b0;
    logic        dht_pronto = 1'b0;
    logic        dht_erro = 1'b0;
    logic [39:0] dht_dados = '0;
    logic        dht_medir, dht_abort, medida_valida, nova_medida, erro_medida;
    logic [7:0]  umidade, temperatura;
    logic [1:0]  falhas;
    logic [3:0]  db_estado;

    agendador_medida_dht11 #(
        .PERIODO_MEDIDA (PERIODO),
        .TIMEOUT        (TMO),
        .MAX_TENTATIVAS (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .parar         (parar),
        .pausa         (pausa),
        .dht_pronto    (dht_pronto),
        .dht_erro      (dht_erro),
        .dht_dados     (dht_dados),
        .dht_medir     (dht_medir),
        .dht_abort     (dht_abort),
        .umidade       (umidade),
        .temperatura   (temperatura),
        .medida_valida (medida_valida),
        .nova_medida   (nova_medida),
        .erro_medida   (erro_medida),
        .falhas        (falhas),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    typedef enum {R_QUADRO, R_AMBOS, R_MUDO} resp_t;

    typedef struct {
        resp_t       resp;
        int          atraso;
        logic [39:0] quadro;
        bit          ok;
        logic [7:0]  u;
        logic [7:0]  t_bruta;
        logic [7:0]  t_media;
        logic [1:0]  falhas;
        bit          erro;
        bit          gap;
    } leitura_t;

    typedef struct {
        logic [7:0] u;
        logic [7:0] t;
    } sb_item_t;

    leitura_t tab_a [10];
    leitura_t tab_b [4];
    sb_item_t exp_q [$];

    int cyc     = 0;
    int n_medir = 0;
    int n_nova  = 0;
    int n_pass  = 0;
    int n_checks = 0;
    int last_d  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_checks++;
        if (atual === esperado) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, cyc);
    endtask

    function automatic logic [7:0] temp_esperada(input leitura_t v);
`ifdef TUSCA_MEDIA_TEMPERATURA_EN
        return v.t_media;
`else
        return v.t_bruta;
`endif
    endfunction

    // Scoreboard consumer: every nova_medida must match the oldest expected frame.
    always @(negedge clock) begin
        sb_item_t e;
        if (dht_medir) n_medir <= n_medir + 1;
        if (nova_medida) begin
            n_nova <= n_nova + 1;
            check("nova_esperada", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("umidade_sb", umidade, e.u);
                check("temperatura_sb", temperatura, e.t);
                check("valida_sb", medida_valida, 1);
            end
        end
    end

    task automatic esperar_medir(output bit ok, output int d);
        ok = 0;
        d  = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clock);
            if (dht_medir) begin
                ok = 1;
                d  = cyc;
                break;
            end
        end
        check("medir_chegou", ok, 1);
    endtask

    task automatic esperar_estado(input logic [3:0] alvo, input int limite);
        bit ok = 0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (db_estado == alvo) begin
                ok = 1;
                break;
            end
        end
        check("estado_alcancado", ok, 1);
    endtask

    task automatic pulso_dht(input logic [39:0] q, input bit com_erro, input int atraso);
        repeat (atraso) @(negedge clock);
        dht_dados  = q;
        dht_pronto = 1'b1;
        dht_erro   = com_erro;
        @(negedge clock);
        dht_pronto = 1'b0;
        dht_erro   = 1'b0;
    endtask

    task automatic pulso_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic fazer_leitura(input leitura_t v);
        bit ok;
        int d;
        bit viu_abort;
        int a;
        esperar_medir(ok, d);
        if (!ok) return;
        if (v.gap) check("periodo_medir", d - last_d, PERIODO);
        last_d = d;
        case (v.resp)
            R_QUADRO: begin
                if (v.ok) exp_q.push_back('{u: v.u, t: temp_esperada(v)});
                pulso_dht(v.quadro, 1'b0, v.atraso);
            end
            R_AMBOS: pulso_dht(v.quadro, 1'b1, v.atraso);
            default: begin
                viu_abort = 0;
                a = 0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clock);
                    if (dht_abort) begin
                        viu_abort = 1;
                        a = cyc;
                        break;
                    end
                end
                check("abort_timeout", viu_abort, 1);
                if (viu_abort) check("atraso_abort", a - d, TMO);
            end
        endcase
        esperar_estado(4'd6, 50);
        @(negedge clock);
        check("falhas", falhas, v.falhas);
        check("erro_medida", erro_medida, v.erro);
        check("umidade", umidade, v.u);
        check("temperatura", temperatura, temp_esperada(v));
        check("medida_valida", medida_valida, 1);
        check("sb_vazio", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d, p, m0, nv0;

        //             resp      atraso quadro          ok  u      t_bruta t_media falhas erro gap
        tab_a[0] = '{R_QUADRO, 10,  40'h123422026a, 1, 8'h12, 8'h22, 8'h22, 2'd0, 0, 0};
        tab_a[1] = '{R_QUADRO, 10,  40'h2345aab2ab, 0, 8'h12, 8'h22, 8'h22, 2'd1, 0, 1};
        tab_a[2] = '{R_QUADRO, 10,  40'h2345aab2c4, 1, 8'h23, 8'haa, 8'h44, 2'd0, 0, 1};
        tab_a[3] = '{R_MUDO,   0,   40'h0,          0, 8'h23, 8'haa, 8'h44, 2'd1, 0, 1};
        tab_a[4] = '{R_MUDO,   0,   40'h0,          0, 8'h23, 8'haa, 8'h44, 2'd2, 0, 1};
        tab_a[5] = '{R_MUDO,   0,   40'h0,          0, 8'h23, 8'haa, 8'h44, 2'd3, 1, 1};
        tab_a[6] = '{R_AMBOS,  10,  40'h2345aab2c4, 0, 8'h23, 8'haa, 8'h44, 2'd3, 1, 1};
        tab_a[7] = '{R_QUADRO, 199, 40'h2345aab2c4, 1, 8'h23, 8'haa, 8'h66, 2'd0, 0, 1};
        tab_a[8] = '{R_QUADRO, 10,  40'h4500190563, 1, 8'h45, 8'h19, 8'h63, 2'd0, 0, 1};
        tab_a[9] = '{R_QUADRO, 10,  40'h123422026a, 1, 8'h12, 8'h22, 8'h63, 2'd0, 0, 1};
        tab_b[0] = '{R_QUADRO, 10,  40'h3000140044, 1, 8'h30, 8'h14, 8'h14, 2'd0, 0, 0};
        tab_b[1] = '{R_QUADRO, 10,  40'h3000160046, 1, 8'h30, 8'h16, 8'h14, 2'd0, 0, 1};
        tab_b[2] = '{R_QUADRO, 10,  40'h3000180048, 1, 8'h30, 8'h18, 8'h15, 2'd0, 0, 1};
        tab_b[3] = '{R_QUADRO, 10,  40'h30001a004a, 1, 8'h30, 8'h1a, 8'h17, 2'd0, 0, 1};

        // Reset state.
        #12;
        check("reset_saidas", {dht_medir, dht_abort, umidade, temperatura, medida_valida,
                               nova_medida, erro_medida, falhas, db_estado}, 0);
        @(negedge clock);
        reset = 1'b1;

        // OCIOSO ignores everything but start.
        pulso_dht(40'h123422026a, 1'b0, 2);
        pausa = 1'b1;
        repeat (20) @(negedge clock);
        pausa = 1'b0;
        check("ocioso_estado", db_estado, 0);
        check("ocioso_sem_medir", n_medir, 0);
        check("ocioso_sem_valida", medida_valida, 0);

        // Table of reads: good, bad checksum, timeouts, erro+pronto, pronto on the timeout cycle.
        pulso_start();
        for (int i = 0; i < 9; i++) fazer_leitura(tab_a[i]);

        // Pause at period count 400 for 5000 cycles.
        fazer_leitura(tab_a[9]);
        while (cyc < last_d + 400) @(negedge clock);
        pausa = 1'b1;
        m0 = n_medir;
        repeat (2) @(negedge clock);
        check("estado_pausado", db_estado, 7);
        repeat (4998) @(negedge clock);
        pausa = 1'b0;
        p = cyc;
        check("sem_medir_em_pausa", n_medir - m0, 0);
        esperar_medir(ok, d);
        if (ok) check("medir_pos_pausa", d - p, 600);

        // parar while waiting for the sensor.
        repeat (5) @(negedge clock);
        check("aguardando", db_estado, 2);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        check("abort_parar", dht_abort, 1);
        check("estado_parar", db_estado, 0);
        check("dados_mantidos", {medida_valida, umidade, temperatura},
              {1'b1, 8'h12, temp_esperada(tab_a[9])});
        nv0 = n_nova;
        pulso_dht(40'h4500190563, 1'b0, 3);
        repeat (10) @(negedge clock);
        check("pronto_tardio_estado", db_estado, 0);
        check("pronto_tardio_nova", n_nova - nv0, 0);
        check("pronto_tardio_umidade", umidade, 8'h12);
        m0 = n_medir;
        repeat (1500) @(negedge clock);
        check("parado_sem_medir", n_medir - m0, 0);

        // start and parar together: parar wins.
        start = 1'b1;
        parar = 1'b1;
        @(negedge clock);
        start = 1'b0;
        parar = 1'b0;
        repeat (3) @(negedge clock);
        check("start_parar_juntos", db_estado, 0);

        // Asynchronous reset in the middle of a read.
        pulso_start();
        esperar_medir(ok, d);
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("reset_assincrono", {dht_medir, dht_abort, umidade, temperatura, medida_valida,
                                   nova_medida, erro_medida, falhas, db_estado}, 0);
        @(negedge clock);
        reset = 1'b1;

        // Fresh run after reset: temperatures 20, 22, 24, 26.
        @(negedge clock);
        pulso_start();
        for (int i = 0; i < 4; i++) fazer_leitura(tab_b[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
